// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage core: drives every inter-stage
// register's stall/flush pair plus PC hold/redirect from a priority of hazard causes.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned PC_W       = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_muldiv,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_redirect_pc,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  output logic            pc_stall,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            stallF,
  output logic            flushF,
  output logic            stallD,
  output logic            flushD,
  output logic            stallE,
  output logic            flushE,
  output logic            stallM,
  output logic            flushM,
  output logic            muldiv_done
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MULDIV_LAT - 1);

  typedef enum logic {IDLE, DROP} fsmState_t;

  fsmState_t        fsm, fsmNext;
  logic [CNT_W-1:0] mcCnt, mcCntNext;
  logic             mulInEx, mcBusy, redirectHit, loadUse;

  assign mulInEx     = ex_valid & ex_is_muldiv;
  assign mcBusy      = mulInEx & (mcCnt != MC_LAST);
  assign redirectHit = ex_redirect & ex_valid;
  assign loadUse     = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign redirect_pc = ex_redirect_pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm   <= IDLE;
      mcCnt <= '0;
    end else begin
      fsm   <= fsmNext;
      mcCnt <= mcCntNext;
    end
  end

  // Hazard priority: dmem wait > mul/div occupancy > redirect > load-use > fetch wait/drop
  always_comb begin
    fsmNext        = fsm;
    pc_stall       = 1'b0;
    redirect_valid = 1'b0;
    stallF         = 1'b0;
    flushF         = 1'b0;
    stallD         = 1'b0;
    flushD         = 1'b0;
    stallE         = 1'b0;
    flushE         = 1'b0;
    stallM         = 1'b0;
    flushM         = 1'b0;
    muldiv_done    = 1'b0;
    if (reset) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else begin
      muldiv_done = mulInEx & (mcCnt == MC_LAST);
      if (dmem_busy) begin
        stallF   = 1'b1;
        stallD   = 1'b1;
        stallE   = 1'b1;
        flushM   = 1'b1;
        pc_stall = 1'b1;
      end else if (mcBusy) begin
        stallF   = 1'b1;
        stallD   = 1'b1;
        flushE   = 1'b1;
        pc_stall = 1'b1;
      end else if (redirectHit) begin
        redirect_valid = 1'b1;
        flushF         = 1'b1;
        flushD         = 1'b1;
        // A fetch still in flight belongs to the wrong path and must be dropped on return
        fsmNext        = imem_busy ? DROP : IDLE;
      end else if (loadUse) begin
        stallF   = 1'b1;
        flushD   = 1'b1;
        pc_stall = 1'b1;
      end else if (imem_busy || (fsm == DROP)) begin
        flushF   = 1'b1;
        pc_stall = imem_busy;
        if (!imem_busy) fsmNext = IDLE;
      end
    end
  end

  // Occupancy counter restarts whenever id_ex loads a new instruction
  always_comb begin
    mcCntNext = mcCnt;
    if (!stallD || flushD) mcCntNext = '0;
    else if (mulInEx && (mcCnt != MC_LAST)) mcCntNext = mcCnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl, checking two instances
// (MULDIV_LAT 4 and 1) against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_valid, ex_mem_read, ex_is_muldiv, ex_redirect;
  logic [63:0] ex_redirect_pc;
  logic        imem_busy, dmem_busy;

  logic [1:0]  pcStall, redirValid, stallF, flushF, stallD, flushD;
  logic [1:0]  stallE, flushE, stallM, flushM, mdDone;
  logic [63:0] redirPc [2];

  int compared   = 0;
  int mismatched = 0;

  int mCnt  [2];
  bit mDrop [2];
  int lat   [2] = '{4, 1};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .PC_W(64)) dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_muldiv(ex_is_muldiv),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_stall(pcStall[0]),
    .redirect_valid(redirValid[0]), .redirect_pc(redirPc[0]),
    .stallF(stallF[0]), .flushF(flushF[0]), .stallD(stallD[0]), .flushD(flushD[0]),
    .stallE(stallE[0]), .flushE(flushE[0]), .stallM(stallM[0]), .flushM(flushM[0]),
    .muldiv_done(mdDone[0])
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(1), .PC_W(64)) dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_is_muldiv(ex_is_muldiv),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_stall(pcStall[1]),
    .redirect_valid(redirValid[1]), .redirect_pc(redirPc[1]),
    .stallF(stallF[1]), .flushF(flushF[1]), .stallD(stallD[1]), .flushD(flushD[1]),
    .stallE(stallE[1]), .flushE(flushE[1]), .stallM(stallM[1]), .flushM(flushM[1]),
    .muldiv_done(mdDone[1])
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] gotVec(input int k);
    return {pcStall[k], redirValid[k], stallF[k], flushF[k], stallD[k], flushD[k],
            stallE[k], flushE[k], stallM[k], flushM[k], mdDone[k]};
  endfunction

  // Reference: pick the winning cause, then derive outputs and next model state
  task automatic modelStep(input int k, output logic [10:0] exp, output int nCnt, output bit nDrop);
    bit ps = 0, rv = 0, sF = 0, fF = 0, sD = 0, fD = 0, sE = 0, fE = 0, sM = 0, fM = 0, md = 0;
    bit mul, loadHit;
    int cause;
    nCnt  = mCnt[k];
    nDrop = mDrop[k];
    mul     = ex_valid && ex_is_muldiv;
    loadHit = ex_valid && ex_mem_read && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (reset) begin
      {fF, fD, fE, fM} = 4'hF;
      nCnt  = 0;
      nDrop = 0;
    end else begin
      md = mul && (mCnt[k] == lat[k] - 1);
      if (dmem_busy)                           cause = 1;
      else if (mul && mCnt[k] < lat[k] - 1)    cause = 2;
      else if (ex_redirect && ex_valid)        cause = 3;
      else if (loadHit)                        cause = 4;
      else if (imem_busy || mDrop[k])          cause = 5;
      else                                     cause = 0;
      case (cause)
        1: begin sF = 1; sD = 1; sE = 1; fM = 1; ps = 1; end
        2: begin sF = 1; sD = 1; fE = 1; ps = 1; end
        3: begin rv = 1; fF = 1; fD = 1; nDrop = imem_busy; end
        4: begin sF = 1; fD = 1; ps = 1; end
        5: begin fF = 1; ps = imem_busy; if (!imem_busy) nDrop = 0; end
        default: ;
      endcase
      if (!sD || fD) nCnt = 0;
      else if (mul && mCnt[k] < lat[k] - 1) nCnt = mCnt[k] + 1;
    end
    exp = {ps, rv, sF, fF, sD, fD, sE, fE, sM, fM, md};
  endtask

  // Called shortly after a falling edge; outputs are settled for the coming rising edge
  task automatic step(input string tag);
    logic [10:0] e;
    int nc [2];
    bit nd [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      modelStep(k, e, nc[k], nd[k]);
      checkVal($sformatf("%s/L%0d", tag, lat[k]), 64'(gotVec(k)), 64'(e));
      checkVal($sformatf("%s/pc%0d", tag, lat[k]), redirPc[k], ex_redirect_pc);
    end
    for (int k = 0; k < 2; k++) begin
      mCnt[k]  = nc[k];
      mDrop[k] = nd[k];
    end
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_is_muldiv = 0; ex_redirect = 0;
    ex_redirect_pc = 64'h0; imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic run(input string tag);
    step(tag);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1;
    mCnt  = '{0, 0};
    mDrop = '{0, 0};
    @(negedge clk);
    step("reset");
    checkVal("resetFlushes", 64'({flushF[0], flushD[0], flushE[0], flushM[0]}), 64'hF);
    @(negedge clk);
    reset = 0;
    run("idle");

    // Load-use on rs2, then the bubble advances
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
    step("loadUse");
    checkVal("loadUseSig", 64'({stallF[0], flushD[0], pcStall[0]}), 64'h7);
    @(negedge clk);
    ex_valid = 0;
    step("loadUseAfter");
    checkVal("loadUseAfterZero", 64'(gotVec(0)), 64'h0);
    @(negedge clk);
    ex_valid = 1; ex_rd = 5'd0; id_rs2 = 5'd0;
    step("loadX0");
    checkVal("loadX0NoStall", 64'(pcStall[0]), 64'h0);
    @(negedge clk);

    // Mul/div occupancy
    idle(); ex_valid = 1; ex_is_muldiv = 1;
    for (int c = 0; c < 3; c++) begin
      step("mulBusy");
      checkVal("mulStall", 64'({stallD[0], flushE[0], mdDone[0]}), 64'h6);
      checkVal("mulLat1NoStall", 64'({stallD[1], mdDone[1]}), 64'h1);
      @(negedge clk);
    end
    step("mulDone");
    checkVal("mulDone", 64'({stallD[0], mdDone[0]}), 64'h1);
    @(negedge clk);
    step("mulRestart");
    checkVal("mulRestartStall", 64'(stallD[0]), 64'h1);
    @(negedge clk);

    // dmem wait freezing a pending redirect
    idle(); ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 64'h8000_0040; dmem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      step("dmemHold");
      checkVal("dmemHoldSig", 64'({flushM[0], stallE[0], redirValid[0]}), 64'h6);
      @(negedge clk);
    end
    dmem_busy = 0;
    step("dmemRelease");
    checkVal("redirAfterDmem", 64'({redirValid[0], flushF[0], flushD[0]}), 64'h7);
    checkVal("redirPc", redirPc[0], 64'h8000_0040);
    @(negedge clk);

    // Redirect during an outstanding fetch: wrong-path return is dropped
    idle(); ex_valid = 1; ex_redirect = 1; imem_busy = 1;
    run("dropEnter");
    idle(); imem_busy = 1;
    run("dropBusy1");
    step("dropBusy2");
    checkVal("dropBusyFlush", 64'({flushF[0], pcStall[0]}), 64'h3);
    @(negedge clk);
    imem_busy = 0;
    step("dropReturn");
    checkVal("dropReturnFlush", 64'({flushF[0], pcStall[0]}), 64'h2);
    @(negedge clk);
    step("dropNext");
    checkVal("dropNextClean", 64'(gotVec(0)), 64'h0);
    @(negedge clk);

    // Load-use outranks fetch wait
    idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; imem_busy = 1;
    step("loadUseImem");
    checkVal("loadUseImemFlushF", 64'(flushF[0]), 64'h0);
    @(negedge clk);

    // dmem wait during a mul: counter keeps advancing
    idle(); ex_valid = 1; ex_is_muldiv = 1; dmem_busy = 1;
    run("mulDmem0");
    run("mulDmem1");
    dmem_busy = 0;
    run("mulDmem2");
    step("mulDmem3");
    checkVal("mulDmemDone", 64'(mdDone[0]), 64'h1);
    @(negedge clk);

    // Reset during DROP with a partly-counted mul
    idle(); ex_valid = 1; ex_redirect = 1; imem_busy = 1;
    run("rstDropEnter");
    idle(); imem_busy = 1; ex_valid = 1; ex_is_muldiv = 1;
    run("rstMul0");
    run("rstMul1");
    reset = 1;
    step("rstMid");
    checkVal("rstMidStalls", 64'({stallF[0], stallD[0], stallE[0], pcStall[0]}), 64'h0);
    @(negedge clk);
    idle();
    step("rstAfterIdle");
    checkVal("rstAfterIdle", 64'(gotVec(0)), 64'h0);
    @(negedge clk);
    ex_valid = 1; ex_is_muldiv = 1;
    run("rstAfterMul");

    // Randomized traffic with small register indices to provoke matches
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom);
      id_use_rs2     = 1'($urandom);
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_mem_read    = ($urandom_range(0, 3) == 0);
      ex_rd          = 5'($urandom_range(0, 3));
      ex_is_muldiv   = ($urandom_range(0, 2) == 0);
      ex_redirect    = ($urandom_range(0, 4) == 0);
      ex_redirect_pc = {32'($urandom), 32'($urandom)};
      imem_busy      = ($urandom_range(0, 2) == 0);
      dmem_busy      = ($urandom_range(0, 5) == 0);
      run("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
